// File: rtl/vector_pkg.sv
// Shared types and helpers for the vector lane dispatcher slice.
// Latency: n/a (types, constants and constant-foldable helpers only).
// Backpressure: n/a.
package vector_pkg;

    // Sequencer states: idle, stepping through beats, holding the result for writeback
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of lanes for a given lane index width
    function automatic int unsigned lanes_of(input int unsigned lane_index_size);
        return 32'd1 << lane_index_size;
    endfunction

    // Beats needed to cover vl elements: ceil(vl / LANES)
    function automatic int unsigned beat_count(input int unsigned vl,
                                               input int unsigned lane_index_size);
        return (vl + lanes_of(lane_index_size) - 32'd1) >> lane_index_size;
    endfunction

endpackage

// File: rtl/vector_elem_select.sv
// Extracts LANES consecutive LEN-bit elements from a full vector bus at a beat index.
// Latency: combinational.
// Backpressure: none; pure mux.
module vector_elem_select
    import vector_pkg::*;
#(
    parameter int LEN             = 32,
    parameter int VECTOR_SIZE     = 8,
    parameter int LANE_INDEX_SIZE = 1,
    parameter int BEAT_W          = 2,
    localparam int LANES          = int'(lanes_of(LANE_INDEX_SIZE))
) (
    input  logic [VECTOR_SIZE*LEN-1:0] vec,
    input  logic [BEAT_W-1:0]          beat,
    output logic [LANES*LEN-1:0]       elems
);

    // Beat b covers elements b*LANES .. b*LANES+LANES-1, which are contiguous on the bus
    always_comb begin
        elems = vec[int'(beat)*(LANES*LEN) +: LANES*LEN];
    end

endmodule

// File: rtl/vector_lane_dispatcher.sv
// Sequences one vector instruction across LANES combinational ALUs and merges results into vd.
// Latency: 1 + ceil(vl/LANES) cycles from accepted start to done (1 cycle when vl is 0).
// Backpressure: result held with done=1 until result_ready; start is ignored while busy.
module vector_lane_dispatcher
    import vector_pkg::*;
#(
    parameter int LEN              = 32,
    parameter int VECTOR_SIZE      = 8,
    parameter int ENTRY_INDEX_SIZE = 3,
    parameter int LANE_INDEX_SIZE  = 1,
    localparam int LANES           = int'(lanes_of(LANE_INDEX_SIZE))
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [ENTRY_INDEX_SIZE:0]     vl,
    input  logic                          vm,
    input  logic [VECTOR_SIZE-1:0]        v0_mask,
    input  logic [VECTOR_SIZE*LEN-1:0]    vs1_all,
    input  logic [VECTOR_SIZE*LEN-1:0]    vs2_all,
    input  logic [VECTOR_SIZE*LEN-1:0]    vd_old_all,
    output logic [LANES*LEN-1:0]          lane_vs1,
    output logic [LANES*LEN-1:0]          lane_vs2,
    output logic [LANES*LEN-1:0]          lane_mask,
    output logic [LANES-1:0]              lane_valid,
    input  logic [LANES*LEN-1:0]          lane_result,
    output logic                          busy,
    output logic                          done,
    input  logic                          result_ready,
    output logic [VECTOR_SIZE*LEN-1:0]    vd_result
);

    // Beat index width; assumes VECTOR_SIZE > LANES so at least one beat bit exists
    localparam int BEAT_W = ENTRY_INDEX_SIZE - LANE_INDEX_SIZE;

    state_t                        state_q;
    state_t                        state_d;
    logic [BEAT_W-1:0]             beat_q;
    logic [ENTRY_INDEX_SIZE:0]     vl_q;
    logic                          vm_q;
    logic [VECTOR_SIZE-1:0]        mask_q;
    logic [VECTOR_SIZE*LEN-1:0]    vs1_q;
    logic [VECTOR_SIZE*LEN-1:0]    vs2_q;
    logic [VECTOR_SIZE*LEN-1:0]    vd_old_q;
    logic [VECTOR_SIZE*LEN-1:0]    res_buf;

    logic                          start_ok;
    logic                          run;
    logic                          beat_last;
    logic [ENTRY_INDEX_SIZE:0]     vl_clamped;
    logic [ENTRY_INDEX_SIZE-1:0]   lane_elem [LANES];
    logic [LANES-1:0]              lane_act;
    logic [LANES*LEN-1:0]          sel_vs1;
    logic [LANES*LEN-1:0]          sel_vs2;

    assign start_ok   = start && (state_q == IDLE);
    assign run        = (state_q == RUN);
    assign vl_clamped = (vl > (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE))
                      ? (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE) : vl;
    assign beat_last  = (32'(beat_q) == beat_count(32'(vl_q), LANE_INDEX_SIZE) - 32'd1);

    vector_elem_select #(
        .LEN             (LEN),
        .VECTOR_SIZE     (VECTOR_SIZE),
        .LANE_INDEX_SIZE (LANE_INDEX_SIZE),
        .BEAT_W          (BEAT_W)
    ) u_sel_vs1 (
        .vec   (vs1_q),
        .beat  (beat_q),
        .elems (sel_vs1)
    );

    vector_elem_select #(
        .LEN             (LEN),
        .VECTOR_SIZE     (VECTOR_SIZE),
        .LANE_INDEX_SIZE (LANE_INDEX_SIZE),
        .BEAT_W          (BEAT_W)
    ) u_sel_vs2 (
        .vec   (vs2_q),
        .beat  (beat_q),
        .elems (sel_vs2)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state: zero-length vectors skip RUN; DONE waits on writeback
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = (vl_clamped == '0) ? DONE : RUN;
            RUN:  if (beat_last) state_d = DONE;
            DONE: if (result_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state only
    always_comb begin
        busy = (state_q != IDLE);
        done = (state_q == DONE);
    end

    // Element index served by each lane in the current beat
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            lane_elem[k] = {beat_q, LANE_INDEX_SIZE'(k)};
        end
    end

    // Lane qualifiers: inside vl is valid, valid and unmasked is active; all zero outside RUN
    always_comb begin
        lane_valid = '0;
        lane_act   = '0;
        lane_mask  = '0;
        for (int k = 0; k < LANES; k++) begin
            if (run) begin
                lane_valid[k] = ({1'b0, lane_elem[k]} < vl_q);
                lane_act[k]   = lane_valid[k] && (vm_q || mask_q[lane_elem[k]]);
                lane_mask[k*LEN +: LEN] = {LEN{lane_act[k]}};
            end
        end
    end

    assign lane_vs1  = run ? sel_vs1 : '0;
    assign lane_vs2  = run ? sel_vs2 : '0;
    assign vd_result = res_buf;

    // Beat counter: cleared on launch, advances every RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        beat_q <= '0;
        else if (start_ok) beat_q <= '0;
        else if (run)      beat_q <= beat_q + 1'b1;
    end

    // Operand latches, captured only on an accepted launch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vl_q     <= '0;
            vm_q     <= 1'b0;
            mask_q   <= '0;
            vs1_q    <= '0;
            vs2_q    <= '0;
            vd_old_q <= '0;
        end else if (start_ok) begin
            vl_q     <= vl_clamped;
            vm_q     <= vm;
            mask_q   <= v0_mask;
            vs1_q    <= vs1_all;
            vs2_q    <= vs2_all;
            vd_old_q <= vd_old_all;
        end
    end

    // Result buffer: preloaded with old vd so tail elements past the last beat stay undisturbed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_buf <= '0;
        end else if (start_ok) begin
            res_buf <= vd_old_all;
        end else if (run) begin
            for (int k = 0; k < LANES; k++) begin
                res_buf[int'(lane_elem[k])*LEN +: LEN] <= lane_act[k]
                    ? lane_result[k*LEN +: LEN]
                    : vd_old_q[int'(lane_elem[k])*LEN +: LEN];
            end
        end
    end

endmodule

// File: tb/tb_vector_lane_dispatcher.sv
module tb_vector_lane_dispatcher;

    localparam int LEN   = 32;
    localparam int VS    = 8;
    localparam int EIS   = 3;
    localparam int LIS   = 1;
    localparam int LANES = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 start = 1'b0;
    logic [EIS:0]         vl = '0;
    logic                 vm = 1'b1;
    logic [VS-1:0]        v0_mask = '0;
    logic [VS*LEN-1:0]    vs1_all;
    logic [VS*LEN-1:0]    vs2_all;
    logic [VS*LEN-1:0]    vd_old_all;
    logic [LANES*LEN-1:0] lane_vs1;
    logic [LANES*LEN-1:0] lane_vs2;
    logic [LANES*LEN-1:0] lane_mask;
    logic [LANES-1:0]     lane_valid;
    logic [LANES*LEN-1:0] lane_result;
    logic                 busy;
    logic                 done;
    logic                 result_ready = 1'b0;
    logic [VS*LEN-1:0]    vd_result;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [EIS:0]  vl;
        logic          vm;
        logic [VS-1:0] mask;
        int            beats;   // RUN cycles before done
        logic [VS-1:0] act;     // elements that take the ALU result
    } vec_t;

    vec_t tbl [6];

    vector_lane_dispatcher #(
        .LEN              (LEN),
        .VECTOR_SIZE      (VS),
        .ENTRY_INDEX_SIZE (EIS),
        .LANE_INDEX_SIZE  (LIS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .vl           (vl),
        .vm           (vm),
        .v0_mask      (v0_mask),
        .vs1_all      (vs1_all),
        .vs2_all      (vs2_all),
        .vd_old_all   (vd_old_all),
        .lane_vs1     (lane_vs1),
        .lane_vs2     (lane_vs2),
        .lane_mask    (lane_mask),
        .lane_valid   (lane_valid),
        .lane_result  (lane_result),
        .busy         (busy),
        .done         (done),
        .result_ready (result_ready),
        .vd_result    (vd_result)
    );

    always #5 clk = ~clk;

    // ALU stub: vs1 + vs2 per lane
    always_comb begin
        for (int k = 0; k < LANES; k++)
            lane_result[k*LEN +: LEN] = lane_vs1[k*LEN +: LEN] + lane_vs2[k*LEN +: LEN];
    end

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Expected merged vector: computed elements are 11*i, the rest keep DEAD0000+i
    function automatic logic [255:0] exp_vec(input logic [VS-1:0] act);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < VS; i++)
            r[i*LEN +: LEN] = act[i] ? 32'(11 * i) : (32'hDEAD0000 + 32'(i));
        return r;
    endfunction

    task automatic launch(input vec_t v);
        @(negedge clk);
        vl = v.vl; vm = v.vm; v0_mask = v.mask; start = 1'b1;
        #1;
        check("busy_not_comb_on_start", 256'(busy), 256'(0));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_row(input vec_t v, input string tag);
        int           cyc;
        int           vlc;
        int           e;
        logic [1:0]   ev;
        logic [1:0]   em;
        vlc = (int'(v.vl) > VS) ? VS : int'(v.vl);
        launch(v);
        cyc = 0;
        while (!done && cyc < 20) begin
            for (int k = 0; k < LANES; k++) begin
                e = cyc * LANES + k;
                ev[k] = (e < vlc);
                em[k] = ev[k] && v.act[e % VS];
            end
            check($sformatf("%s_valid_b%0d", tag, cyc), 256'(lane_valid), 256'(ev));
            check($sformatf("%s_mask_b%0d", tag, cyc), 256'(lane_mask),
                  256'({{32{em[1]}}, {32{em[0]}}}));
            check($sformatf("%s_vs1_b%0d", tag, cyc), 256'(lane_vs1),
                  256'({32'(cyc*2+1), 32'(cyc*2)}));
            check($sformatf("%s_vs2_b%0d", tag, cyc), 256'(lane_vs2),
                  256'({32'(10*(cyc*2+1)), 32'(10*(cyc*2))}));
            check($sformatf("%s_busy_b%0d", tag, cyc), 256'(busy), 256'(1));
            @(negedge clk);
            cyc++;
        end
        check($sformatf("%s_run_cycles", tag), 256'(cyc), 256'(v.beats));
        check($sformatf("%s_done", tag), 256'({busy, done}), 256'(2'b11));
        check($sformatf("%s_vd", tag), vd_result, exp_vec(v.act));
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check($sformatf("%s_idle_after", tag), 256'({busy, done}), 256'(0));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int   cyc;
        logic [255:0] snap;

        for (int i = 0; i < VS; i++) begin
            vs1_all[i*LEN +: LEN]    = 32'(i);
            vs2_all[i*LEN +: LEN]    = 32'(10 * i);
            vd_old_all[i*LEN +: LEN] = 32'hDEAD0000 + 32'(i);
        end

        tbl[0] = '{vl: 4'd8,  vm: 1'b1, mask: 8'h00,        beats: 4, act: 8'hFF};
        tbl[1] = '{vl: 4'd5,  vm: 1'b1, mask: 8'h00,        beats: 3, act: 8'h1F};
        tbl[2] = '{vl: 4'd8,  vm: 1'b0, mask: 8'b1010_0101, beats: 4, act: 8'hA5};
        tbl[3] = '{vl: 4'd0,  vm: 1'b1, mask: 8'hFF,        beats: 0, act: 8'h00};
        tbl[4] = '{vl: 4'd12, vm: 1'b1, mask: 8'h00,        beats: 4, act: 8'hFF};
        tbl[5] = '{vl: 4'd3,  vm: 1'b0, mask: 8'b0000_0110, beats: 2, act: 8'h06};

        // Reset state
        @(negedge clk);
        check("rst_busy_done", 256'({busy, done}), 256'(0));
        check("rst_lane_valid", 256'(lane_valid), 256'(0));
        check("rst_lane_mask", 256'(lane_mask), 256'(0));
        check("rst_vd", vd_result, 256'(0));
        rst_n = 1'b1;

        for (int r = 0; r < 6; r++)
            run_row(tbl[r], $sformatf("row%0d", r));

        // Backpressure: done and vd held, start pulses ignored while waiting
        launch(tbl[0]);
        cyc = 0;
        while (!done && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("bp_reach_done", 256'(done), 256'(1));
        snap = vd_result;
        check("bp_vd_initial", snap, exp_vec(8'hFF));
        for (int i = 0; i < 5; i++) begin
            vl = 4'd3; vm = 1'b0; v0_mask = 8'h00; start = (i % 2 == 0);
            @(negedge clk);
            check($sformatf("bp_done_hold%0d", i), 256'({busy, done}), 256'(2'b11));
            check($sformatf("bp_vd_hold%0d", i), vd_result, exp_vec(8'hFF));
        end
        start = 1'b0;
        result_ready = 1'b1;
        @(negedge clk);
        result_ready = 1'b0;
        check("bp_idle", 256'({busy, done}), 256'(0));
        @(negedge clk);
        check("bp_no_spurious_run", 256'({busy, done}), 256'(0));

        // Asynchronous reset in the middle of RUN (beat 1)
        launch(tbl[0]);
        @(negedge clk);
        check("mid_beat1_vs1", 256'(lane_vs1), 256'({32'd3, 32'd2}));
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy_done", 256'({busy, done}), 256'(0));
        check("arst_lane_valid", 256'(lane_valid), 256'(0));
        check("arst_lane_mask", 256'(lane_mask), 256'(0));
        check("arst_lane_vs1", 256'(lane_vs1), 256'(0));
        check("arst_lane_vs2", 256'(lane_vs2), 256'(0));
        check("arst_vd", vd_result, 256'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_idle", 256'({busy, done}), 256'(0));
        run_row(tbl[2], "post_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
